// File: rtl/buffer_arbiter.sv
// buffer_arbiter: arbitrates a shared packet buffer between host word accesses and USB rx/tx byte streams.
// Optional packet inactivity timeout is enabled by defining BUFARB_TIMEOUT_EN.
module buffer_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_wr_req,
    input  logic       host_rd_req,
    input  logic [1:0] host_size,
    input  logic       host_flush,
    input  logic       rx_start,
    input  logic       rx_byte_valid,
    input  logic       tx_start,
    input  logic       tx_byte_req,
    input  logic       pkt_done,
    input  logic [6:0] buffer_occupancy,
    output logic       host_ack,
    output logic       host_err,
    output logic       store_rx_packet_data,
    output logic       get_tx_packet_data,
    output logic       store_tx_data,
    output logic       get_rx_data,
    output logic [1:0] data_size,
    output logic       clear,
    output logic       buffer_reserved,
    output logic [1:0] owner,
    output logic       overrun,
    output logic       underrun
);
    typedef enum logic [2:0] {IDLE, HOST, RX_PKT, TX_PKT, FLUSH} state_t;
    state_t state, nxt;
    logic is_wr, host_bad, timeout;
    logic nxt_ack, nxt_err, nxt_store, nxt_get, nxt_clear;
    logic [7:0] bytes;

    assign buffer_reserved = state == RX_PKT || state == TX_PKT;
    assign owner = state == HOST ? 2'd1 : state == RX_PKT ? 2'd2 : state == TX_PKT ? 2'd3 : 2'd0;
    assign store_rx_packet_data = state == RX_PKT && rx_byte_valid && buffer_occupancy < 7'd64;
    assign get_tx_packet_data = state == TX_PKT && tx_byte_req && buffer_occupancy != 7'd0;

`ifdef BUFARB_TIMEOUT_EN
    logic [7:0] idle_cnt;
    assign timeout = buffer_reserved && idle_cnt == 8'hff;
    // Count silent cycles inside a packet; any byte strobe or a state change restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= 8'd0;
        else
            idle_cnt <= (buffer_reserved && nxt == state && !store_rx_packet_data && !get_tx_packet_data) ? idle_cnt + 8'd1 : 8'd0;
    end
`else
    assign timeout = 1'b0;
`endif

    // Next state and the registered host/clear responses, with fixed-priority grant in IDLE.
    always_comb begin
        nxt = state;
        nxt_ack = 1'b0;
        nxt_err = 1'b0;
        nxt_store = 1'b0;
        nxt_get = 1'b0;
        nxt_clear = 1'b0;
        bytes = data_size == 2'd0 ? 8'd1 : data_size == 2'd1 ? 8'd2 : 8'd4;
        host_bad = data_size == 2'd3 || (is_wr ? ({1'b0, buffer_occupancy} + bytes > 8'd64) : ({1'b0, buffer_occupancy} < bytes));
        case (state)
            IDLE: begin
                nxt = host_flush ? FLUSH : rx_start ? RX_PKT : tx_start ? TX_PKT : (host_wr_req || host_rd_req) ? HOST : IDLE;
                nxt_clear = host_flush;
            end
            HOST: begin
                nxt = IDLE;
                nxt_err = host_bad;
                nxt_ack = !host_bad;
                nxt_store = !host_bad && is_wr;
                nxt_get = !host_bad && !is_wr;
            end
            RX_PKT, TX_PKT: begin
                nxt = (pkt_done || timeout) ? IDLE : state;
                nxt_clear = timeout;
            end
            FLUSH: begin
                nxt = IDLE;
                nxt_ack = 1'b1;
            end
            default: nxt = IDLE;
        endcase
    end

    // State register, host access latch, registered strobes and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            is_wr <= 1'b0;
            data_size <= 2'd0;
            host_ack <= 1'b0;
            host_err <= 1'b0;
            store_tx_data <= 1'b0;
            get_rx_data <= 1'b0;
            clear <= 1'b0;
            overrun <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && nxt == HOST) begin
                is_wr <= host_wr_req;
                data_size <= host_size;
            end
            host_ack <= nxt_ack;
            host_err <= nxt_err;
            store_tx_data <= nxt_store;
            get_rx_data <= nxt_get;
            clear <= nxt_clear;
            overrun <= clear ? 1'b0 : overrun | (state == RX_PKT && rx_byte_valid && buffer_occupancy >= 7'd64);
            underrun <= clear ? 1'b0 : underrun | (state == TX_PKT && tx_byte_req && buffer_occupancy == 7'd0);
        end
    end
endmodule

// File: tb/tb_buffer_arbiter.sv
// tb_buffer_arbiter: scoreboard bench for buffer_arbiter; define BUFARB_TIMEOUT_EN to exercise the timeout.
module tb_buffer_arbiter;
    localparam logic [6:0] ACK = 7'b1000000, ERR = 7'b0100000, SRX = 7'b0010000, GTX = 7'b0001000;
    localparam logic [6:0] STX = 7'b0000100, GRX = 7'b0000010, CLR = 7'b0000001;

    logic clk = 1'b0, rst = 1'b1;
    logic host_wr_req = 0, host_rd_req = 0, host_flush = 0, rx_start = 0, rx_byte_valid = 0;
    logic tx_start = 0, tx_byte_req = 0, pkt_done = 0;
    logic [1:0] host_size = 0;
    logic [6:0] buffer_occupancy = 0;
    logic host_ack, host_err, store_rx_packet_data, get_tx_packet_data, store_tx_data, get_rx_data;
    logic clear, buffer_reserved, overrun, underrun;
    logic [1:0] data_size, owner;

    typedef struct {
        int at;
        logic [6:0] v;
        string name;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int cyc = 0, tests = 0, fails = 0, first;
    logic [6:0] ev;

    buffer_arbiter dut (
        .clk(clk), .rst(rst), .host_wr_req(host_wr_req), .host_rd_req(host_rd_req),
        .host_size(host_size), .host_flush(host_flush), .rx_start(rx_start),
        .rx_byte_valid(rx_byte_valid), .tx_start(tx_start), .tx_byte_req(tx_byte_req),
        .pkt_done(pkt_done), .buffer_occupancy(buffer_occupancy), .host_ack(host_ack),
        .host_err(host_err), .store_rx_packet_data(store_rx_packet_data),
        .get_tx_packet_data(get_tx_packet_data), .store_tx_data(store_tx_data),
        .get_rx_data(get_rx_data), .data_size(data_size), .clear(clear),
        .buffer_reserved(buffer_reserved), .owner(owner), .overrun(overrun), .underrun(underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: retire overdue expectations, then match any output event against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() != 0 && sb[0].at < cyc) begin
                e = sb.pop_front();
                tests++;
                fails++;
                $display("FAIL %s missing: expected %b at cycle %0d, nothing seen by cycle %0d", e.name, e.v, e.at, cyc);
            end
            ev = {host_ack, host_err, store_rx_packet_data, get_tx_packet_data, store_tx_data, get_rx_data, clear};
            if (ev != 7'd0) begin
                tests++;
                if (sb.size() == 0 || sb[0].at != cyc) begin
                    fails++;
                    $display("FAIL unexpected_event cycle %0d got %b required none", cyc, ev);
                end else begin
                    e = sb.pop_front();
                    if (e.v != ev) begin
                        fails++;
                        $display("FAIL %s cycle %0d got %b required %b", e.name, cyc, ev, e.v);
                    end
                end
            end
        end
    end

    task automatic push(input int at, input logic [6:0] v, input string n);
        sb.push_back('{at, v, n});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [7:0] got, input logic [7:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got %0h required %0h", n, got, req);
        end
    endtask

    task automatic host(input logic wr, input logic rd, input logic [1:0] sz, input logic [6:0] oc,
                        input logic [6:0] v, input string n);
        host_wr_req = wr;
        host_rd_req = rd;
        host_size = sz;
        buffer_occupancy = oc;
        push(cyc + 2, v, n);
        step;
        host_wr_req = 0;
        host_rd_req = 0;
        chk({n, "_size"}, {6'd0, data_size}, {6'd0, sz});
        chk({n, "_owner"}, {6'd0, owner}, 8'd1);
        step;
        step;
    endtask

    initial begin
        #3;
        chk("rst_owner", {6'd0, owner}, 8'd0);
        chk("rst_reserved", {7'd0, buffer_reserved}, 8'd0);
        chk("rst_size", {6'd0, data_size}, 8'd0);
        chk("rst_flags", {6'd0, overrun, underrun}, 8'd0);
        chk("rst_strobes", {1'b0, host_ack, host_err, store_tx_data, get_rx_data, clear, store_rx_packet_data, get_tx_packet_data}, 8'd0);
        step;
        rst = 0;
        step;
        buffer_occupancy = 10;
        rx_start = 1;
        step;
        rx_start = 0;
        chk("rx_owner", {6'd0, owner}, 8'd2);
        chk("rx_reserved", {7'd0, buffer_reserved}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            rx_byte_valid = 1;
            push(cyc, SRX, "rx_store");
            step;
        end
        rx_byte_valid = 0;
        pkt_done = 1;
        step;
        pkt_done = 0;
        chk("rx_end_owner", {6'd0, owner}, 8'd0);
        chk("rx_end_reserved", {7'd0, buffer_reserved}, 8'd0);
        host(1, 0, 2, 62, ERR, "wr_overflow");
        host(0, 1, 2, 8, ACK | GRX, "rd_ok");
        host(1, 0, 0, 63, ACK | STX, "wr_exact_64");
        host(1, 0, 1, 63, ERR, "wr_65");
        host(0, 1, 1, 1, ERR, "rd_short");
        host(0, 1, 0, 1, ACK | GRX, "rd_exact");
        host(1, 1, 0, 0, ACK | STX, "wr_over_rd");
        host(0, 1, 3, 64, ERR, "rd_illegal");
        buffer_occupancy = 0;
        rx_start = 1;
        host_flush = 1;
        host_wr_req = 1;
        host_size = 0;
        push(cyc + 1, CLR, "flush_clear");
        push(cyc + 2, ACK, "flush_ack");
        push(cyc + 4, ACK | STX, "held_write");
        step;
        rx_start = 0;
        host_flush = 0;
        chk("flush_owner", {6'd0, owner}, 8'd0);
        chk("flush_reserved", {7'd0, buffer_reserved}, 8'd0);
        step;
        step;
        host_wr_req = 0;
        chk("held_write_owner", {6'd0, owner}, 8'd1);
        step;
        step;
        buffer_occupancy = 0;
        tx_start = 1;
        step;
        tx_start = 0;
        chk("tx_owner", {6'd0, owner}, 8'd3);
        tx_byte_req = 1;
        step;
        chk("underrun_set", {7'd0, underrun}, 8'd1);
        buffer_occupancy = 5;
        push(cyc, GTX, "tx_fetch_at_done");
        pkt_done = 1;
        step;
        tx_byte_req = 0;
        pkt_done = 0;
        chk("tx_end_owner", {6'd0, owner}, 8'd0);
        chk("underrun_sticky", {7'd0, underrun}, 8'd1);
        host_flush = 1;
        push(cyc + 1, CLR, "flush2_clear");
        push(cyc + 2, ACK, "flush2_ack");
        step;
        host_flush = 0;
        step;
        chk("underrun_cleared", {7'd0, underrun}, 8'd0);
        host(1, 0, 3, 0, ERR, "wr_illegal");
        buffer_occupancy = 64;
        rx_start = 1;
        step;
        rx_start = 0;
        rx_byte_valid = 1;
        tx_start = 1;
        host_rd_req = 1;
        step;
        tx_start = 0;
        host_rd_req = 0;
        chk("ignore_owner", {6'd0, owner}, 8'd2);
        chk("overrun_set", {7'd0, overrun}, 8'd1);
        buffer_occupancy = 3;
        #1;
        chk("pre_rst_store", {7'd0, store_rx_packet_data}, 8'd1);
        #1;
        rst = 1;
        #1;
        chk("async_owner", {6'd0, owner}, 8'd0);
        chk("async_reserved", {7'd0, buffer_reserved}, 8'd0);
        chk("async_store", {7'd0, store_rx_packet_data}, 8'd0);
        chk("async_overrun", {7'd0, overrun}, 8'd0);
        chk("async_size", {6'd0, data_size}, 8'd0);
        rx_byte_valid = 0;
        step;
        chk("rst_hold_owner", {6'd0, owner}, 8'd0);
        #2;
        rst = 0;
        chk("rst_release_owner", {6'd0, owner}, 8'd0);
        step;
        buffer_occupancy = 0;
        rx_start = 1;
        step;
        rx_start = 0;
        first = cyc;
`ifdef BUFARB_TIMEOUT_EN
        push(first + 256, CLR, "timeout_clear");
        repeat (255) step;
        chk("timeout_pre_owner", {6'd0, owner}, 8'd2);
        step;
        chk("timeout_owner", {6'd0, owner}, 8'd0);
        chk("timeout_reserved", {7'd0, buffer_reserved}, 8'd0);
`else
        repeat (300) step;
        chk("no_timeout_owner", {6'd0, owner}, 8'd2);
        chk("no_timeout_reserved", {7'd0, buffer_reserved}, 8'd1);
        pkt_done = 1;
        step;
        pkt_done = 0;
        chk("no_timeout_end", {6'd0, owner}, 8'd0);
`endif
        repeat (3) step;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/buffer_arbiter.md
BUFFER_ARBITER -- requirements
Module: buffer_arbiter

Interface
REQ-001 SHALL have ports, one per line, name direction width meaning:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- host_wr_req  in  1  host requests a word store into the buffer.
- host_rd_req  in  1  host requests a word fetch from the buffer.
- host_size  in  2  byte count of the host access: 0=1, 1=2, 2=4, 3=illegal.
- host_flush  in  1  host requests a buffer clear.
- rx_start  in  1  USB receiver opens a packet.
- rx_byte_valid  in  1  USB receiver presents one byte.
- tx_start  in  1  USB transmitter opens a packet.
- tx_byte_req  in  1  USB transmitter wants one byte.
- pkt_done  in  1  the active USB packet has ended.
- buffer_occupancy  in  7  byte count from the data buffer, 0..64.
- host_ack  out  1  one-cycle completion of a host access.
- host_err  out  1  one-cycle rejection of a host access.
- store_rx_packet_data  out  1  byte-store strobe to the buffer.
- get_tx_packet_data  out  1  byte-fetch strobe to the buffer.
- store_tx_data  out  1  word-store strobe to the buffer.
- get_rx_data  out  1  word-fetch strobe to the buffer.
- data_size  out  2  registered copy of host_size for the buffer.
- clear  out  1  buffer clear strobe.
- buffer_reserved  out  1  high while a USB packet owns the buffer.
- owner  out  2  0=none, 1=host, 2=rx, 3=tx.
- overrun  out  1  sticky; set by a byte store attempted at occupancy 64.
- underrun  out  1  sticky; set by a byte fetch attempted at occupancy 0.

Function
REQ-002 SHALL implement states IDLE, HOST, RX_PKT, TX_PKT and FLUSH, encoded on owner as 0, 1, 2, 3 and 0 respectively.
REQ-003 SHALL arbitrate in IDLE with fixed priority host_flush > rx_start > tx_start > host request, with one grant per cycle.
REQ-004 SHALL, on IDLE with host_flush, enter FLUSH, pulse clear for exactly 1 cycle, then pulse host_ack and return to IDLE (2 cycles total).
REQ-005 SHALL, on rx_start in IDLE, enter RX_PKT the next cycle with buffer_reserved=1.
REQ-006 SHALL, on tx_start in IDLE, enter TX_PKT the next cycle with buffer_reserved=1.
REQ-007 SHALL, in RX_PKT, assert store_rx_packet_data in the same cycle as rx_byte_valid when occupancy<64.
REQ-008 SHALL, in RX_PKT with occupancy=64, suppress the store strobe and set overrun instead.
REQ-009 SHALL, in TX_PKT, assert get_tx_packet_data in the same cycle as tx_byte_req when occupancy>0.
REQ-010 SHALL, in TX_PKT with occupancy=0, suppress the fetch strobe and set underrun instead.
REQ-011 SHALL, on pkt_done in RX_PKT or TX_PKT, return to IDLE the next cycle with buffer_reserved=0; a byte strobe in that same cycle is still honoured.
REQ-012 SHALL, on a host request in IDLE, enter HOST and latch host_size into data_size.
REQ-013 SHALL, in HOST on the next cycle, either pulse store_tx_data (write) or get_rx_data (read) for 1 cycle together with host_ack, or pulse host_err alone, then return to IDLE; grant-to-ack latency is 2 cycles.
REQ-014 SHALL raise host_err when host_size=3.
REQ-015 SHALL raise host_err on a write when occupancy+bytes>64, with the sum computed 8 bits wide.
REQ-016 SHALL raise host_err on a read when occupancy<bytes.
REQ-017 SHALL, when host_wr_req and host_rd_req are both high, serve the write and drop the read.
REQ-018 SHALL ignore host requests while buffer_reserved=1; they are not queued and the host holds its request.
REQ-019 SHALL ignore rx_start and tx_start outside IDLE.
REQ-020 SHALL keep all strobes mutually exclusive, with at most one high per cycle.
REQ-021 SHALL clear overrun and underrun on the clear pulse.

Reset
REQ-022 SHALL, on rst high at any time (including mid-packet), asynchronously force state IDLE, owner=0, data_size=0 and every strobe, ack, err, buffer_reserved, overrun and underrun to 0.
REQ-023 SHALL hold those reset values until the first rising clk edge after rst falls.

Configuration
REQ-024 SHALL, with BUFARB_TIMEOUT_EN defined, run an 8-bit idle counter in RX_PKT/TX_PKT that is reset by any byte strobe or state entry.
REQ-025 SHALL, with BUFARB_TIMEOUT_EN defined, force IDLE, buffer_reserved=0 and a 1-cycle clear when the counter reaches 255.
REQ-026 SHALL, without BUFARB_TIMEOUT_EN, have no counter and leave packet states only via pkt_done or rst.

Verification
REQ-027 SHALL cover: rx_start, 3x rx_byte_valid, pkt_done -> 3 store_rx_packet_data pulses, owner 2->0, buffer_reserved 1->0.
REQ-028 SHALL cover: occupancy=62, host_wr_req with host_size=2 -> host_err after 2 cycles, no store_tx_data.
REQ-029 SHALL cover: occupancy=8, host_rd_req with host_size=2 -> get_rx_data and host_ack together 2 cycles after request, data_size=2.
REQ-030 SHALL cover: rx_start, host_flush and host_wr_req in the same IDLE cycle -> FLUSH, one clear pulse, host_ack; the host write is served later.
REQ-031 SHALL cover: TX_PKT at occupancy=0 with tx_byte_req -> no get_tx_packet_data, underrun=1 until clear.
REQ-032 SHALL cover: rst pulse mid RX_PKT -> all outputs 0 asynchronously; with BUFARB_TIMEOUT_EN, 255 silent cycles -> clear pulse and owner=0.
